uart_txrx_cfg: RTL and testbench
================================

UART_TXRX_CFG -- requirements
Module: uart_txrx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 48000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, transmitted stop bits, legal values 1 or 2.
REQ-006 SHALL have parameter RX_SAMPLES, default 3, RX samples per bit, odd and >=3.
REQ-007 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-008 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-009 SHALL have port tx_vld  in  1  TX data valid.
REQ-010 SHALL have port tx_rdy  out  1  TX ready to accept a byte.
REQ-011 SHALL have port tx_data  in  DATA_BITS  TX payload.
REQ-012 SHALL have port tx_uart  out  1  serial TX line, idle high.
REQ-013 SHALL have port rx_uart  in  1  serial RX line, asynchronous to clk.
REQ-014 SHALL have port rx_vld  out  1  RX data valid, held until accepted.
REQ-015 SHALL have port rx_rdy  in  1  RX consumer ready.
REQ-016 SHALL have port rx_data  out  DATA_BITS  received payload.
REQ-017 SHALL have ports rx_parity_err, rx_frame_err, rx_overrun_err, rx_break  out  1 each  one-cycle error pulses.

Function
REQ-018 SHALL compute CLKS_PER_BIT = CLK_FREQUENCY/BAUD_RATE (integer division) and raise an elaboration error if CLKS_PER_BIT < 2*(RX_SAMPLES+1) or if any parameter is outside its legal range.
REQ-019 SHALL accept a TX byte on a cycle where tx_vld && tx_rdy; tx_rdy deasserts on the next cycle.
REQ-020 SHALL run the TX FSM through TX_IDLE -> TX_START -> TX_DATA -> TX_PARITY (skipped when PARITY=0) -> TX_STOP -> TX_IDLE.
REQ-021 SHALL drive the start bit from the cycle after acceptance and hold every bit exactly CLKS_PER_BIT cycles; data is sent LSB first.
REQ-022 SHALL transmit a parity bit equal to the XOR of the data bits for even parity and its inverse for odd parity.
REQ-023 SHALL send STOP_BITS high bits and reassert tx_rdy on the cycle after the last stop-bit cycle, giving (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles from acceptance to tx_rdy.
REQ-024 SHALL pass rx_uart through a 2-flop synchronizer (reset value 1); all RX logic uses the synchronized value.
REQ-025 SHALL run the RX FSM through RX_IDLE -> RX_START -> RX_DATA -> RX_PARITY (skipped when PARITY=0) -> RX_STOP -> RX_IDLE, plus RX_WAIT_HIGH.
REQ-026 SHALL leave RX_IDLE on the first cycle the synchronized line is low, with the bit timer starting at 0.
REQ-027 SHALL sample each bit at timer values k*(CLKS_PER_BIT/(RX_SAMPLES+1)), k=1..RX_SAMPLES, and take the majority vote as the bit value.
REQ-028 SHALL treat a start bit that votes 1 as a false start: return to RX_IDLE with no output and no error.
REQ-029 SHALL check only the first stop bit; after its last sample, RX returns to RX_IDLE without waiting for the end of the bit.
REQ-030 SHALL update rx_data and assert rx_vld on the cycle after the last stop-bit sample; rx_vld stays high until a cycle with rx_rdy high and then clears.
REQ-031 SHALL pulse rx_parity_err or rx_frame_err (stop bit votes 0) coincident with that rx_vld rise; the frame is still delivered.
REQ-032 SHALL detect a break (all data bits 0, parity bit 0 if present, stop bit 0), pulse rx_break only, deliver no data, and enter RX_WAIT_HIGH.
REQ-033 SHALL, on a frame error, enter RX_WAIT_HIGH; RX_WAIT_HIGH returns to RX_IDLE on the first synchronized high.
REQ-034 SHALL, when a frame completes while rx_vld=1 and rx_rdy=0, pulse rx_overrun_err and keep the old rx_data (new data discarded); rx_rdy=1 in that same cycle counts as acceptance, so no overrun occurs.
REQ-035 SHALL keep TX and RX fully independent, so simultaneous operation is legal.

Reset
REQ-036 SHALL, while reset is high, asynchronously force tx_uart=1, tx_rdy=1, rx_vld=0, rx_data=0, all error pulses 0, both FSMs to idle, counters to 0 and synchronizer flops to 1.
REQ-037 SHALL abort any frame in progress on reset; the first post-reset TX frame starts with a full start bit.

Verification (CLK_FREQUENCY=1000000, BAUD_RATE=100000, CLKS_PER_BIT=10)
REQ-038 SHALL check: DATA_BITS=8, PARITY=0, tx 0xA5 -> tx_uart low 10 cycles, then 1,0,1,0,0,1,0,1, then high; tx_rdy back after 100 cycles.
REQ-039 SHALL check: PARITY=1, STOP_BITS=2, loopback 0x07 -> parity bit 1, tx_rdy after 120 cycles, rx_data=0x07 with no error pulses.
REQ-040 SHALL check: PARITY=2 with the frame for 0x03 and parity bit 0 -> rx_vld with rx_data=0x03 and rx_parity_err pulse.
REQ-041 SHALL check: 3-cycle low glitch on idle rx_uart -> no rx_vld and no error pulses; a 0x00 frame with low stop bit held low 30 cycles -> rx_break, then a normal frame is received afterwards.
REQ-042 SHALL check: two frames (0x11, 0x22) with rx_rdy=0 -> rx_data stays 0x11 and rx_overrun_err pulses once.
REQ-043 SHALL check: reset asserted mid TX frame -> tx_uart=1 and tx_rdy=1 immediately, before the next clk edge.

Source files
------------

// File: rtl/uart_txrx_cfg.sv
// Parameterised UART transmitter and receiver sharing one clock.
// TX: valid/ready byte input, start/data/parity/stop serialisation.
// RX: 2-flop synchronizer, majority-vote oversampling, parity/frame/break/
// overrun reporting with a held rx_vld until the consumer accepts.
module uart_txrx_cfg #(
  parameter int CLK_FREQUENCY = 48000000,
  parameter int BAUD_RATE     = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_SAMPLES    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_vld,
  output logic                 tx_rdy,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_uart,
  input  logic                 rx_uart,
  output logic                 rx_vld,
  input  logic                 rx_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun_err,
  output logic                 rx_break
);

  localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
  localparam int SAMPLE_STEP  = CLKS_PER_BIT / (RX_SAMPLES + 1);
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam int PW           = $clog2(SAMPLE_STEP);
  localparam int VW           = $clog2(RX_SAMPLES + 1);
  localparam logic ODD        = (PARITY == 2);

  localparam logic [TW-1:0] BIT_END   = TW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(SAMPLE_STEP - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2 * (RX_SAMPLES + 1) || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      RX_SAMPLES < 3 || (RX_SAMPLES % 2) == 0) begin : g_bad_params
    $error("uart_txrx_cfg: illegal parameter combination");
  end

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  typedef struct packed {
    tx_state_e            state;
    logic [TW-1:0]        timer;
    logic [3:0]           bits;
    logic                 stops;
    logic [DATA_BITS-1:0] shift;
    logic                 par;
    logic                 line;
  } tx_regs_t;

  typedef struct packed {
    rx_state_e            state;
    logic [TW-1:0]        timer;
    logic [PW-1:0]        phase;
    logic [VW-1:0]        nsmp;
    logic [VW-1:0]        ones;
    logic [3:0]           bits;
    logic [DATA_BITS-1:0] shift;
    logic                 par;
    logic [DATA_BITS-1:0] data;
    logic                 vld;
    logic                 perr;
    logic                 ferr;
    logic                 oerr;
    logic                 brk;
  } rx_regs_t;

  localparam tx_regs_t TX_RESET = '{state: TX_IDLE, timer: '0, bits: '0, stops: 1'b0,
                                    shift: '0, par: 1'b0, line: 1'b1};
  localparam rx_regs_t RX_RESET = '{state: RX_IDLE, timer: '0, phase: '0, nsmp: '0, ones: '0,
                                    bits: '0, shift: '0, par: 1'b0, data: '0, vld: 1'b0,
                                    perr: 1'b0, ferr: 1'b0, oerr: 1'b0, brk: 1'b0};

  tx_regs_t   tx_q, tx_d;
  rx_regs_t   rx_q, rx_d;
  logic [1:0] sync_q;
  logic       rx_s;
  logic       smp_hit, smp_last, bit_val, bit_end, brk_pat, par_bad;

  // TX state and datapath registers.
  // NOTE: non-blocking assignments in clocked blocks so every flop updates from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_q <= TX_RESET;
    else       tx_q <= tx_d;
  end

  // TX next state: accept in idle, then hold each bit for CLKS_PER_BIT cycles.
  // NOTE: start from the held value so every path assigns every field and no latch is inferred.
  always_comb begin
    tx_d = tx_q;
    if (tx_q.state == TX_IDLE) begin
      tx_d.timer = '0;
      if (tx_vld) begin
        tx_d.state = TX_START;
        tx_d.shift = tx_data;
        tx_d.par   = ^tx_data ^ ODD;
        tx_d.line  = 1'b0;
      end
    end else begin
      tx_d.timer = tx_q.timer + 1'b1;
      if (tx_q.timer == BIT_END) begin
        tx_d.timer = '0;
        case (tx_q.state)
          TX_START: begin
            tx_d.state = TX_DATA;
            tx_d.bits  = '0;
            tx_d.line  = tx_q.shift[0];
          end
          TX_DATA: begin
            tx_d.shift = tx_q.shift >> 1;
            if (tx_q.bits != DATA_LAST) begin
              tx_d.bits = tx_q.bits + 1'b1;
              tx_d.line = tx_q.shift[1];
            end else if (PARITY != 0) begin
              tx_d.state = TX_PARITY;
              tx_d.line  = tx_q.par;
            end else begin
              tx_d.state = TX_STOP;
              tx_d.stops = 1'b0;
              tx_d.line  = 1'b1;
            end
          end
          TX_PARITY: begin
            tx_d.state = TX_STOP;
            tx_d.stops = 1'b0;
            tx_d.line  = 1'b1;
          end
          TX_STOP: begin
            if (tx_q.stops == 1'(STOP_BITS - 1)) tx_d.state = TX_IDLE;
            else                                 tx_d.stops = 1'b1;
            tx_d.line = 1'b1;
          end
          default: begin
            tx_d.state = TX_IDLE;
            tx_d.line  = 1'b1;
          end
        endcase
      end
    end
  end

  assign tx_rdy  = (tx_q.state == TX_IDLE);
  assign tx_uart = tx_q.line;

  // Two-flop synchronizer for the asynchronous RX line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_uart};
  end

  assign rx_s = sync_q[1];

  // Sample points fall where the phase counter wraps, k*SAMPLE_STEP for k=1..RX_SAMPLES.
  assign smp_hit  = (rx_q.phase == '0) && (rx_q.timer != '0) && (rx_q.nsmp != VW'(RX_SAMPLES));
  assign smp_last = smp_hit && (rx_q.nsmp == VW'(RX_SAMPLES - 1));
  assign bit_val  = (rx_q.ones + VW'(rx_s)) > VW'(RX_SAMPLES / 2);
  assign bit_end  = (rx_q.timer == BIT_END);
  assign brk_pat  = (rx_q.shift == '0) && ((PARITY == 0) || !rx_q.par);
  assign par_bad  = (PARITY != 0) && (rx_q.par != (^rx_q.shift ^ ODD));

  // RX state, sample counters, output data and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_q <= RX_RESET;
    else       rx_q <= rx_d;
  end

  // RX next state: oversample each bit, vote, assemble, and report on the last stop sample.
  always_comb begin
    rx_d      = rx_q;
    rx_d.perr = 1'b0;
    rx_d.ferr = 1'b0;
    rx_d.oerr = 1'b0;
    rx_d.brk  = 1'b0;
    if (rx_q.vld && rx_rdy) rx_d.vld = 1'b0;

    if (rx_q.state inside {RX_START, RX_DATA, RX_PARITY, RX_STOP}) begin
      rx_d.timer = rx_q.timer + 1'b1;
      rx_d.phase = (rx_q.phase == PH_LAST) ? '0 : rx_q.phase + 1'b1;
      if (smp_hit) begin
        rx_d.nsmp = rx_q.nsmp + 1'b1;
        rx_d.ones = rx_q.ones + VW'(rx_s);
      end
      if (bit_end) begin
        rx_d.timer = '0;
        rx_d.phase = '0;
        rx_d.nsmp  = '0;
        rx_d.ones  = '0;
      end
    end else begin
      rx_d.timer = '0;
      rx_d.phase = '0;
      rx_d.nsmp  = '0;
      rx_d.ones  = '0;
    end

    case (rx_q.state)
      RX_IDLE:      if (!rx_s) rx_d.state = RX_START;
      RX_START: begin
        if (smp_last && bit_val) rx_d.state = RX_IDLE;
        else if (bit_end) begin
          rx_d.state = RX_DATA;
          rx_d.bits  = '0;
        end
      end
      RX_DATA: begin
        if (smp_last) rx_d.shift = {bit_val, rx_q.shift[DATA_BITS-1:1]};
        if (bit_end) begin
          if (rx_q.bits != DATA_LAST) rx_d.bits  = rx_q.bits + 1'b1;
          else if (PARITY != 0)       rx_d.state = RX_PARITY;
          else                        rx_d.state = RX_STOP;
        end
      end
      RX_PARITY: begin
        if (smp_last) rx_d.par = bit_val;
        if (bit_end)  rx_d.state = RX_STOP;
      end
      RX_STOP: begin
        if (smp_last) begin
          if (!bit_val && brk_pat) begin
            rx_d.brk   = 1'b1;
            rx_d.state = RX_WAIT_HIGH;
          end else begin
            rx_d.perr  = par_bad;
            rx_d.ferr  = !bit_val;
            rx_d.state = bit_val ? RX_IDLE : RX_WAIT_HIGH;
            if (rx_q.vld && !rx_rdy) begin
              rx_d.oerr = 1'b1;
            end else begin
              rx_d.data = rx_q.shift;
              rx_d.vld  = 1'b1;
            end
          end
        end
      end
      RX_WAIT_HIGH: if (rx_s) rx_d.state = RX_IDLE;
      default:      rx_d.state = RX_IDLE;
    endcase
  end

  assign rx_vld         = rx_q.vld;
  assign rx_data        = rx_q.data;
  assign rx_parity_err  = rx_q.perr;
  assign rx_frame_err   = rx_q.ferr;
  assign rx_overrun_err = rx_q.oerr;
  assign rx_break       = rx_q.brk;

endmodule

// File: tb/tb_uart_txrx_cfg.sv
// Directed bench for uart_txrx_cfg at 10 clocks per bit.
// Instance A: 8N1 (TX waveform, RX glitch/break/overrun, reset abort).
// Instance B: 8E2 with TX looped into RX.  Instance C: 8O1 RX parity error.
module tb_uart_txrx_cfg;

  localparam int CPB = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_tx_vld, a_tx_rdy, a_tx_uart, a_rx_uart, a_rx_vld, a_rx_rdy;
  logic       a_pe, a_fe, a_oe, a_brk;
  logic [7:0] a_tx_data, a_rx_data;
  logic       b_tx_vld, b_tx_rdy, b_tx_uart, b_rx_vld, b_rx_rdy;
  logic       b_pe, b_fe, b_oe, b_brk;
  logic [7:0] b_tx_data, b_rx_data;
  logic       c_tx_vld, c_tx_rdy, c_tx_uart, c_rx_uart, c_rx_vld, c_rx_rdy;
  logic       c_pe, c_fe, c_oe, c_brk;
  logic [7:0] c_tx_data, c_rx_data;

  uart_txrx_cfg #(.CLK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .RX_SAMPLES(3)) u_a (
    .clk(clk), .reset(reset), .tx_vld(a_tx_vld), .tx_rdy(a_tx_rdy), .tx_data(a_tx_data),
    .tx_uart(a_tx_uart), .rx_uart(a_rx_uart), .rx_vld(a_rx_vld), .rx_rdy(a_rx_rdy),
    .rx_data(a_rx_data), .rx_parity_err(a_pe), .rx_frame_err(a_fe),
    .rx_overrun_err(a_oe), .rx_break(a_brk));

  uart_txrx_cfg #(.CLK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(2), .RX_SAMPLES(3)) u_b (
    .clk(clk), .reset(reset), .tx_vld(b_tx_vld), .tx_rdy(b_tx_rdy), .tx_data(b_tx_data),
    .tx_uart(b_tx_uart), .rx_uart(b_tx_uart), .rx_vld(b_rx_vld), .rx_rdy(b_rx_rdy),
    .rx_data(b_rx_data), .rx_parity_err(b_pe), .rx_frame_err(b_fe),
    .rx_overrun_err(b_oe), .rx_break(b_brk));

  uart_txrx_cfg #(.CLK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1), .RX_SAMPLES(3)) u_c (
    .clk(clk), .reset(reset), .tx_vld(c_tx_vld), .tx_rdy(c_tx_rdy), .tx_data(c_tx_data),
    .tx_uart(c_tx_uart), .rx_uart(c_rx_uart), .rx_vld(c_rx_vld), .rx_rdy(c_rx_rdy),
    .rx_data(c_rx_data), .rx_parity_err(c_pe), .rx_frame_err(c_fe),
    .rx_overrun_err(c_oe), .rx_break(c_brk));

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  int a_rise = 0, a_pe_n = 0, a_fe_n = 0, a_oe_n = 0, a_brk_n = 0;
  int b_rise = 0, b_pe_n = 0, b_fe_n = 0, b_oe_n = 0, b_brk_n = 0;
  int c_rise = 0, c_pe_n = 0, c_fe_n = 0;
  logic a_prev = 1'b0, b_prev = 1'b0, c_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int inst, input logic [7:0] d, input logic p, input logic f);
    exp_t e;
    e.inst = inst; e.data = d; e.perr = p; e.ferr = f;
    exp_q.push_back(e);
  endtask

  function automatic int pending(input int inst);
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].inst == inst) n++;
    return n;
  endfunction

  // Called on each rx_vld rise: compare against the oldest expectation for that instance.
  task automatic pop_check(input int inst, input logic v, input logic [7:0] d,
                           input logic p, input logic f);
    int idx = -1;
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].inst == inst) idx = i;
    if (idx < 0) begin
      check($sformatf("rx%0d_unexpected_vld", inst), 32'(v), 0);
    end else begin
      check($sformatf("rx%0d_data", inst), 32'(d), 32'(exp_q[idx].data));
      check($sformatf("rx%0d_parity_err", inst), 32'(p), 32'(exp_q[idx].perr));
      check($sformatf("rx%0d_frame_err", inst), 32'(f), 32'(exp_q[idx].ferr));
      exp_q.delete(idx);
    end
  endtask

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (a_rx_vld && !a_prev) begin
      a_rise <= a_rise + 1;
      pop_check(0, a_rx_vld, a_rx_data, a_pe, a_fe);
    end
    a_prev  <= a_rx_vld;
    a_pe_n  <= a_pe_n + (a_pe ? 1 : 0);
    a_fe_n  <= a_fe_n + (a_fe ? 1 : 0);
    a_oe_n  <= a_oe_n + (a_oe ? 1 : 0);
    a_brk_n <= a_brk_n + (a_brk ? 1 : 0);
  end

  always @(negedge clk) begin
    if (b_rx_vld && !b_prev) begin
      b_rise <= b_rise + 1;
      pop_check(1, b_rx_vld, b_rx_data, b_pe, b_fe);
    end
    b_prev  <= b_rx_vld;
    b_pe_n  <= b_pe_n + (b_pe ? 1 : 0);
    b_fe_n  <= b_fe_n + (b_fe ? 1 : 0);
    b_oe_n  <= b_oe_n + (b_oe ? 1 : 0);
    b_brk_n <= b_brk_n + (b_brk ? 1 : 0);
  end

  always @(negedge clk) begin
    if (c_rx_vld && !c_prev) begin
      c_rise <= c_rise + 1;
      pop_check(2, c_rx_vld, c_rx_data, c_pe, c_fe);
    end
    c_prev <= c_rx_vld;
    c_pe_n <= c_pe_n + (c_pe ? 1 : 0);
    c_fe_n <= c_fe_n + (c_fe ? 1 : 0);
  end

  function automatic logic get_tx(input int w);
    return (w == 0) ? a_tx_uart : b_tx_uart;
  endfunction

  function automatic logic get_rdy(input int w);
    return (w == 0) ? a_tx_rdy : b_tx_rdy;
  endfunction

  task automatic set_tx(input int w, input logic v, input logic [7:0] d);
    if (w == 0) begin a_tx_vld = v; a_tx_data = d; end
    else        begin b_tx_vld = v; b_tx_data = d; end
  endtask

  task automatic set_rx(input int w, input logic v);
    if (w == 0) a_rx_uart = v;
    else        c_rx_uart = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx_rdy(input int w, input string tag);
    for (int i = 0; i < 300 && !get_rdy(w); i++) @(negedge clk);
    check({tag, "_rdy_wait"}, 32'(get_rdy(w)), 1);
  endtask

  // Send one byte on TX instance w and check every line cycle plus tx_rdy timing.
  task automatic tx_frame(input int w, input logic [7:0] d, input int par_mode,
                          input int nstop, input string tag);
    logic exp_bits[$];
    int   ok;
    int   early = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (par_mode == 1) exp_bits.push_back(^d);
    if (par_mode == 2) exp_bits.push_back(~^d);
    for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
    wait_tx_rdy(w, tag);
    set_tx(w, 1'b1, d);
    @(negedge clk);
    set_tx(w, 1'b0, 8'h00);
    for (int b = 0; b < exp_bits.size(); b++) begin
      ok = 0;
      for (int c = 0; c < CPB; c++) begin
        if (get_tx(w) === exp_bits[b]) ok++;
        if (get_rdy(w) !== 1'b0) early++;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d_cycles", tag, b), 32'(ok), CPB);
    end
    check({tag, "_rdy_low_during_frame"}, 32'(early), 0);
    check({tag, "_rdy_back"}, 32'(get_rdy(w)), 1);
    check({tag, "_line_idle"}, 32'(get_tx(w)), 1);
  endtask

  // Drive one 8-bit frame on RX line w; stop level and stop length are free for break tests.
  task automatic rx_send(input int w, input logic [7:0] d, input bit has_par, input logic par_bit,
                         input logic stop_lvl, input int stop_cycles);
    set_rx(w, 1'b0);
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      set_rx(w, d[i]);
      idle(CPB);
    end
    if (has_par) begin
      set_rx(w, par_bit);
      idle(CPB);
    end
    set_rx(w, stop_lvl);
    idle(stop_cycles);
    set_rx(w, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_tx(0, 1'b0, 8'h00);
    set_tx(1, 1'b0, 8'h00);
    c_tx_vld = 1'b0; c_tx_data = 8'h00;
    a_rx_uart = 1'b1; c_rx_uart = 1'b1;
    a_rx_rdy = 1'b1; b_rx_rdy = 1'b1; c_rx_rdy = 1'b1;
    idle(3);

    // Reset state.
    check("rst_tx_uart", 32'(a_tx_uart), 1);
    check("rst_tx_rdy", 32'(a_tx_rdy), 1);
    check("rst_rx_vld", 32'(a_rx_vld), 0);
    check("rst_rx_data", 32'(a_rx_data), 0);
    check("rst_err_pulses", 32'({a_pe, a_fe, a_oe, a_brk}), 0);
    reset = 1'b0;
    idle(3);

    // 8N1 transmit of 0xA5: 100 cycles acceptance to ready.
    tx_frame(0, 8'hA5, 0, 1, "t1");

    // 8E2 loopback of 0x07: parity bit 1, 120 cycles, clean receive.
    push_exp(1, 8'h07, 1'b0, 1'b0);
    tx_frame(1, 8'h07, 1, 2, "t2");
    idle(20);
    check("t2_rx_delivered", 32'(pending(1)), 0);
    check("t2_rx_rises", 32'(b_rise), 1);
    check("t2_err_counts", 32'(b_pe_n + b_fe_n + b_oe_n + b_brk_n), 0);

    // 8O1 receive of 0x03 with a wrong (0) parity bit.
    push_exp(2, 8'h03, 1'b1, 1'b0);
    rx_send(1, 8'h03, 1'b1, 1'b0, 1'b1, CPB);
    idle(20);
    check("t3_rx_delivered", 32'(pending(2)), 0);
    check("t3_parity_pulses", 32'(c_pe_n), 1);
    check("t3_frame_pulses", 32'(c_fe_n), 0);

    // 3-cycle glitch on idle line: false start, nothing reported.
    set_rx(0, 1'b0);
    idle(3);
    set_rx(0, 1'b1);
    idle(40);
    check("t4_glitch_no_vld", 32'(a_rise), 0);
    check("t4_glitch_no_err", 32'(a_pe_n + a_fe_n + a_oe_n + a_brk_n), 0);

    // Break: 0x00 with the stop bit held low for 30 cycles.
    rx_send(0, 8'h00, 1'b0, 1'b0, 1'b0, 30);
    idle(20);
    check("t4_break_pulses", 32'(a_brk_n), 1);
    check("t4_break_no_frame_err", 32'(a_fe_n), 0);
    check("t4_break_no_vld", 32'(a_rise), 0);

    // Normal frame after the break.
    push_exp(0, 8'h5A, 1'b0, 1'b0);
    rx_send(0, 8'h5A, 1'b0, 1'b0, 1'b1, CPB);
    idle(20);
    check("t4_after_break_delivered", 32'(pending(0)), 0);
    check("t4_after_break_rises", 32'(a_rise), 1);

    // Overrun: two frames without the consumer ready.
    a_rx_rdy = 1'b0;
    push_exp(0, 8'h11, 1'b0, 1'b0);
    rx_send(0, 8'h11, 1'b0, 1'b0, 1'b1, CPB);
    idle(20);
    rx_send(0, 8'h22, 1'b0, 1'b0, 1'b1, CPB);
    idle(20);
    check("t5_data_kept", 32'(a_rx_data), 32'h11);
    check("t5_vld_held", 32'(a_rx_vld), 1);
    check("t5_overrun_pulses", 32'(a_oe_n), 1);
    check("t5_rises", 32'(a_rise), 2);
    a_rx_rdy = 1'b1;
    idle(2);
    check("t5_vld_cleared", 32'(a_rx_vld), 0);

    // Reset in the middle of a TX frame forces the line idle at once.
    wait_tx_rdy(0, "t6");
    set_tx(0, 1'b1, 8'h00);
    @(negedge clk);
    set_tx(0, 1'b0, 8'h00);
    idle(25);
    check("t6_mid_frame_line_low", 32'(a_tx_uart), 0);
    check("t6_mid_frame_busy", 32'(a_tx_rdy), 0);
    #2 reset = 1'b1;
    #1;
    check("t6_async_tx_uart", 32'(a_tx_uart), 1);
    check("t6_async_tx_rdy", 32'(a_tx_rdy), 1);
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    // First frame after reset starts with a full start bit.
    tx_frame(0, 8'h3C, 0, 1, "t7");
    idle(5);
    check("end_no_pending", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
